data_shift_sched: RTL
=====================

// Module: data_shift_sched
// PURPOSE
//  Flow controller in front of data_shift. Pairs each packet's SOP flit with its
//  metadata record and gates flits into data_shift, which has no backpressure.
//  Issues flits only against downstream FIFO credits. Reserves a credit for, and
//  inserts a 1-cycle bubble after, any tail flit that makes data_shift emit an
//  extra flit. Sits between the parser/metadata FIFOs and data_shift.
// PARAMETERS
//  CREDITS  16  downstream FIFO slots (flits); power of two not required, >=2
// PORTS
//  clk              in   1    core clock
//  rst              in   1    reset; asynchronous, active-low
//  in_pkt_valid     in   1    upstream flit valid
//  in_pkt_sop       in   1    upstream start of packet
//  in_pkt_eop       in   1    upstream end of packet
//  in_pkt_data      in   256  upstream flit data
//  in_pkt_empty     in   5    empty bytes on EOP flit
//  in_pkt_ready     out  1    flit accepted when valid&ready
//  in_meta_valid    in   1    metadata record valid
//  in_meta_data     in   metadata_t  record; .prot selects UDP bypass
//  in_meta_ready    out  1    metadata popped when valid&ready
//  ds_pkt_valid/sop/eop/data/empty  out  1/1/1/256/5  flit to data_shift
//  ds_meta_valid    out  1    metadata valid to data_shift (same cycle as SOP)
//  ds_meta_data     out  metadata_t  metadata to data_shift
//  credit_return    in   1    pulse: downstream FIFO freed one slot
//  err_orphan       out  1    sticky: non-SOP flit seen in IDLE (flit dropped)
//  err_credit       out  1    sticky: credit_return with counter already at CREDITS
// BEHAVIOUR
//  Reset: state=IDLE, credit=CREDITS, in_*_ready=0, ds_*_valid=0, err_*=0.
//  Data path is combinational, with zero latency. ds_pkt_* = in_pkt_*.
//  ds_pkt_valid = in_pkt_valid & in_pkt_ready. ds_meta_valid = sop handshake.
//  ext (extra flit) = eop & ~(prot==PROT_UDP) & (empty < 8). prot is the value
//  latched at the SOP handshake, or the live in_meta_data.prot for 1-flit packets.
//  need = 1 + ext. in_pkt_ready requires credit >= need.
//  FSM:
//   IDLE: ready = in_pkt_valid & in_pkt_sop & in_meta_valid & credit>=need.
//     The SOP handshake pops metadata and latches udp.
//     eop&ext -> GAP; eop&~ext -> IDLE; otherwise -> BODY.
//     A non-SOP valid flit in IDLE is dropped: ready=1, ds_pkt_valid=0, err_orphan set.
//   BODY: ready = credit>=need; in_meta_ready=0.
//     eop handshake: ext -> GAP, else -> IDLE.
//     An SOP flit in BODY is forwarded as data; this is not an error.
//   GAP: all ready=0 for exactly 1 cycle -> IDLE.
//     This cycle is where data_shift emits its extra flit.
//  Credit counter, width $clog2(CREDITS+1): next = credit - consumed + credit_return.
//   consumed = need on a forwarded handshake, else 0. A simultaneous issue and
//   return is netted in the same cycle. At CREDITS with a return and no issue:
//   hold the counter and set err_credit. Never underflows because of the ready gating.
//  Back-to-back: with no ext, SOP of the next packet is accepted the cycle after EOP.
//  Reset mid-packet: the partial packet is abandoned. Upstream must flush its own state.
// CONFIGURATION
//  SCHED_STATS_EN defined: adds 32-bit outputs stat_pkts (SOP handshakes),
//   stat_ext (ext EOPs) and stat_stall (cycles with in_pkt_valid & ~in_pkt_ready).
//   Counters wrap and reset to 0.
//  SCHED_STATS_EN undefined: these ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  1. TCP 3-flit pkt, empty=4 on EOP, credits=16: accepted on 3 consecutive cycles,
//     then 1 GAP cycle; credit=12 before any return.
//  2. UDP 1-flit pkt, empty=2: no GAP, credit-1; next SOP is accepted the following cycle.
//  3. credit=1, TCP 1-flit pkt, empty=0: held with ready=0. One credit_return pulse,
//     then accepted the next cycle; credit=0.
//  4. SOP valid, meta not valid for 5 cycles: ready=0 throughout. Meta arrives,
//     and pkt+meta handshake in the same cycle.
//  5. Non-SOP flit in IDLE: dropped, err_orphan=1 and held until reset.
//  6. credit_return at credit=CREDITS: counter stays at 16, err_credit=1.
//     Assert rst mid-BODY: all outputs return to reset values immediately.

Source files
------------

// File: rtl/data_shift_sched.sv
// rtl/data_shift_sched.sv - credit-gated flit/metadata scheduler in front of data_shift
//
// Purpose: pairs each packet's SOP flit with its metadata record, forwards flits
// to data_shift (which cannot stall) only against downstream FIFO credits, and
// reserves an extra credit plus a one-cycle bubble after any tail flit that makes
// data_shift emit an additional flit.
//
// Ports:
//   clk, rst (asynchronous, active-low)
//   in_pkt_*      upstream flit stream (valid/ready, sop/eop, 256b data, 5b empty)
//   in_meta_*     upstream metadata record (valid/ready, metadata_t)
//   ds_pkt_*      flit to data_shift (valid only, no backpressure)
//   ds_meta_*     metadata to data_shift, valid on the SOP handshake cycle
//   credit_return one pulse per downstream FIFO slot freed
//   err_orphan    sticky: non-SOP flit arrived while idle and was dropped
//   err_credit    sticky: credit returned while the counter was already full
//
// Optional build macro SCHED_STATS_EN adds 32-bit wrapping counters
// stat_pkts, stat_ext and stat_stall.

package data_shift_sched_pkg;
    localparam logic [7:0] PROT_UDP = 8'd17;

    typedef struct packed {
        logic [7:0]  prot;
        logic [7:0]  hdr_len;
        logic [15:0] flow_id;
    } metadata_t;
endpackage

module data_shift_sched
    import data_shift_sched_pkg::*;
#(
    parameter int CREDITS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_pkt_valid,
    input  logic         in_pkt_sop,
    input  logic         in_pkt_eop,
    input  logic [255:0] in_pkt_data,
    input  logic [4:0]   in_pkt_empty,
    output logic         in_pkt_ready,
    input  logic         in_meta_valid,
    input  metadata_t    in_meta_data,
    output logic         in_meta_ready,
    output logic         ds_pkt_valid,
    output logic         ds_pkt_sop,
    output logic         ds_pkt_eop,
    output logic [255:0] ds_pkt_data,
    output logic [4:0]   ds_pkt_empty,
    output logic         ds_meta_valid,
    output metadata_t    ds_meta_data,
    input  logic         credit_return,
    output logic         err_orphan,
    output logic         err_credit
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]  stat_pkts,
    output logic [31:0]  stat_ext,
    output logic [31:0]  stat_stall
`endif
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    typedef enum logic [1:0] {S_IDLE, S_BODY, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          udp_q, udp_d;
    logic          err_orphan_q, err_orphan_d;
    logic          err_credit_q, err_credit_d;

`ifdef SCHED_STATS_EN
    logic [31:0]   stat_pkts_q, stat_pkts_d;
    logic [31:0]   stat_ext_q, stat_ext_d;
    logic [31:0]   stat_stall_q, stat_stall_d;
`endif

    logic          live_udp;
    logic          udp_eff;
    logic          ext;
    logic [CW-1:0] need;
    logic [CW-1:0] consumed;
    logic          credit_ok;
    logic          orphan;
    logic          fwd;
    logic          sop_hs;

    always_comb begin
        live_udp = (in_meta_data.prot == PROT_UDP);
        // A 1-flit packet has no latched protocol yet, so use the live record.
        udp_eff   = (state_q == S_IDLE) ? live_udp : udp_q;
        ext       = in_pkt_eop & ~udp_eff & (in_pkt_empty < 5'd8);
        need      = ext ? CW'(2) : CW'(1);
        credit_ok = (credit_q >= need);

        in_pkt_ready  = 1'b0;
        in_meta_ready = 1'b0;
        orphan        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_pkt_valid & ~in_pkt_sop) begin
                    // Swallow the orphan so upstream cannot wedge on it.
                    in_pkt_ready = 1'b1;
                    orphan       = 1'b1;
                end else begin
                    in_pkt_ready  = in_pkt_valid & in_meta_valid & credit_ok;
                    in_meta_ready = in_pkt_ready;
                end
            end
            S_BODY:  in_pkt_ready = credit_ok;
            default: ;
        endcase

        fwd      = in_pkt_valid & in_pkt_ready & ~orphan;
        sop_hs   = fwd & (state_q == S_IDLE);
        consumed = fwd ? need : '0;

        state_d = state_q;
        case (state_q)
            S_IDLE: if (sop_hs) state_d = in_pkt_eop ? (ext ? S_GAP : S_IDLE) : S_BODY;
            S_BODY: if (fwd & in_pkt_eop) state_d = ext ? S_GAP : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        udp_d        = sop_hs ? live_udp : udp_q;
        err_orphan_d = err_orphan_q | orphan;
        err_credit_d = err_credit_q;
        if (credit_return & ~fwd & (credit_q == CRED_MAX)) begin
            credit_d     = credit_q;
            err_credit_d = 1'b1;
        end else begin
            credit_d = credit_q - consumed + CW'(credit_return);
        end

`ifdef SCHED_STATS_EN
        stat_pkts_d  = stat_pkts_q + 32'(sop_hs);
        stat_ext_d   = stat_ext_q + 32'(fwd & in_pkt_eop & ext);
        stat_stall_d = stat_stall_q + 32'(in_pkt_valid & ~in_pkt_ready);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            credit_q     <= CRED_MAX;
            udp_q        <= 1'b0;
            err_orphan_q <= 1'b0;
            err_credit_q <= 1'b0;
`ifdef SCHED_STATS_EN
            stat_pkts_q  <= '0;
            stat_ext_q   <= '0;
            stat_stall_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            udp_q        <= udp_d;
            err_orphan_q <= err_orphan_d;
            err_credit_q <= err_credit_d;
`ifdef SCHED_STATS_EN
            stat_pkts_q  <= stat_pkts_d;
            stat_ext_q   <= stat_ext_d;
            stat_stall_q <= stat_stall_d;
`endif
        end
    end

    assign ds_pkt_valid  = fwd;
    assign ds_pkt_sop    = in_pkt_sop;
    assign ds_pkt_eop    = in_pkt_eop;
    assign ds_pkt_data   = in_pkt_data;
    assign ds_pkt_empty  = in_pkt_empty;
    assign ds_meta_valid = sop_hs;
    assign ds_meta_data  = in_meta_data;
    assign err_orphan    = err_orphan_q;
    assign err_credit    = err_credit_q;

`ifdef SCHED_STATS_EN
    assign stat_pkts  = stat_pkts_q;
    assign stat_ext   = stat_ext_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule
